mem_sram_ctrl: RTL and testbench
================================

Name: mem_sram_ctrl

Overview:
- Memory-stage data-memory controller. It replaces the single-cycle data memory with an off-chip 16-bit asynchronous SRAM.
- Accepts load/store requests from the EXE→MEM pipeline register: ALU result as the address, reg2 as the store data, plus the read/write enables.
- Splits each 32-bit access into two 16-bit SRAM phases and returns the 32-bit load data to the MEM/WB path.
- Drives `ready` low while busy; the pipeline uses `~ready` as a global freeze.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_WAIT, 2: cycles held per 16-bit phase. Minimum 1.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- rd_en  in  1  load request (MEM_R_EN).
- wr_en  in  1  store request (MEM_W_EN).
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (reg2).
- read_data  out  32  load result.
- ready  out  1  request complete / no request pending. Freeze = ~ready.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM word address.
- SRAM_WE_N  out  1  SRAM write strobe, active-low.

Behaviour:
- Reset values: state=IDLE, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, wait counter=0. Reset asserted mid-access aborts immediately to these values; no partial write completes after reset is asserted.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en or wr_en is 1, go to LO and load the counter with SRAM_WAIT-1.
  - ready = ~(rd_en | wr_en), combinational.
- LO:
  - Drive SRAM_ADDR = {idx[SRAM_AW-2:0],1'b0}, where idx = (address - BASE_ADDR) >> 2, 32-bit unsigned subtract.
  - On a write, SRAM_WE_N=0 and DQ=write_data[15:0].
  - Counter decrements each cycle. At 0: on a read, latch DQ into read_data[15:0]; go to HI and reload the counter.
- HI:
  - Same as LO, but SRAM_ADDR LSB=1 and the upper halfword is used: DQ=write_data[31:16] on a write; latch read_data[31:16] on a read.
  - At counter 0, go to DONE.
- DONE: ready=1 for exactly one cycle, SRAM_WE_N=1, DQ=Z. Next state is IDLE unconditionally.
- Latency with a request first seen in IDLE at cycle 0: ready rises in cycle 2·SRAM_WAIT+1. Default SRAM_WAIT=2 gives cycle 5.
- ready=0 in LO and HI regardless of inputs.
- Requester must hold rd_en, wr_en, address and write_data stable until ready=1; the freeze guarantees this.
- rd_en and wr_en both 1: treated as a write; read_data unchanged.
- read_data holds its last value between loads; stores never modify it.
- Back-to-back requests: after DONE the FSM always passes through one IDLE cycle. A new request present in that cycle starts LO next cycle and ready stays 0.
- SRAM_DQ is driven only when SRAM_WE_N=0; otherwise it is Z.
- Address bits [1:0] are ignored (word access only).
- Address below BASE_ADDR wraps modulo 2^32 and is truncated to the index width, unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- When defined:
  - Adds output addr_err (1 bit, reset 0).
  - A request with address < BASE_ADDR or idx ≥ 2^(SRAM_AW-1) goes IDLE→DONE directly: no SRAM strobe, read_data unchanged.
  - addr_err=1 during that DONE cycle only.
- When undefined: no addr_err port; all addresses are accessed after truncation as above.

Test Plan:
- Store: wr_en=1, address=0x400, write_data=0xDEADBEEF → SRAM word 0=0xBEEF and word 1=0xDEAD; SRAM_WE_N low for 2 cycles per phase; ready=1 at cycle 5 only.
- Load: rd_en=1, address=0x400 after the store above → read_data=0xDEADBEEF at cycle 5; SRAM_WE_N stays 1 throughout.
- Index mapping: store 0x12345678 at 0x408 → SRAM_ADDR 4 gets 0x5678 and SRAM_ADDR 5 gets 0x1234; a load from 0x408 returns 0x12345678.
- Back-to-back store then load held stable: second ready at cycle 11. No request: ready=1 continuously and state stays IDLE.
- Reset mid-access: rst=0 during HI of a store → SRAM_WE_N=1, DQ=Z and read_data=0 immediately. After release with no request, ready=1.
- Both enables: rd_en=wr_en=1 at 0x404 with 0xCAFEF00D → behaves as a store and read_data is unchanged. With SRAM_ADDR_CHECK_EN, address 0x3FC → addr_err=1 at cycle 1 and no SRAM_WE_N pulse.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// ============================================================================
// Module   : mem_sram_ctrl
// Purpose  : MEM-stage data-memory controller that serves 32-bit loads and
//            stores from a 16-bit asynchronous SRAM in two halfword phases.
//            Optional macro SRAM_ADDR_CHECK_EN adds the addr_err output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SRAM_WAIT = 2,
    parameter int          SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N
`ifdef SRAM_ADDR_CHECK_EN
    ,
    output logic               addr_err
`endif
);

    localparam int                 c_CNT_W  = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(SRAM_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [31:0]        r_read_data;
    logic               w_req;
    logic               w_is_rd;
    logic [31:0]        w_off;
    logic [SRAM_AW-2:0] w_word_idx;
    logic               w_bad;
    logic               w_lat_lo;
    logic               w_lat_hi;
    logic               w_unused;

    assign w_req      = rd_en | wr_en;
    // A simultaneous read and write is serviced as a store only.
    assign w_is_rd    = rd_en & ~wr_en;
    assign w_off      = address - BASE_ADDR;
    assign w_word_idx = w_off[SRAM_AW:2];

`ifdef SRAM_ADDR_CHECK_EN
    logic r_addr_err;
    logic w_err_set;

    assign w_bad     = (address < BASE_ADDR) || (|w_off[31:SRAM_AW+1]);
    assign w_err_set = (r_state == ST_IDLE) && w_req && w_bad;
    assign addr_err  = r_addr_err;
    assign w_unused  = ^w_off[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= w_err_set;
        end
    end
`else
    assign w_bad    = 1'b0;
    assign w_unused = ^{w_off[31:SRAM_AW+1], w_off[1:0]};
`endif

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        ready      = 1'b0;
        SRAM_WE_N  = 1'b1;
        SRAM_ADDR  = '0;
        w_lat_lo   = 1'b0;
        w_lat_hi   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    if (w_bad) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next     = ST_LO;
                        w_cnt_next = c_RELOAD;
                    end
                end
            end
            ST_LO: begin
                SRAM_ADDR = {w_word_idx, 1'b0};
                SRAM_WE_N = ~wr_en;
                if (r_cnt == '0) begin
                    w_lat_lo   = w_is_rd;
                    w_next     = ST_HI;
                    w_cnt_next = c_RELOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_HI: begin
                SRAM_ADDR = {w_word_idx, 1'b1};
                SRAM_WE_N = ~wr_en;
                if (r_cnt == '0) begin
                    w_lat_hi = w_is_rd;
                    w_next   = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                ready  = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // The bus is released whenever the write strobe is inactive so the SRAM can drive reads.
    assign SRAM_DQ = (!SRAM_WE_N) ? ((r_state == ST_HI) ? write_data[31:16] : write_data[15:0])
                                  : 16'hzzzz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_read_data <= 32'h0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_lat_lo) begin
                r_read_data[15:0] <= SRAM_DQ;
            end
            if (w_lat_hi) begin
                r_read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    assign read_data = r_read_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
// ============================================================================
// Module   : tb_mem_sram_ctrl
// Purpose  : Self-checking bench for mem_sram_ctrl with an SRAM model and a
//            transaction-level expectation timeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sram_ctrl;

    localparam logic [31:0] c_BASE = 32'd1024;
    localparam int          c_W    = 2;
    localparam int          c_AW   = 18;
    localparam logic [31:0] c_MASK = (32'd1 << (c_AW - 1)) - 32'd1;

    logic            clk = 1'b0;
    logic            rst;
    logic            rd_en;
    logic            wr_en;
    logic [31:0]     address;
    logic [31:0]     write_data;
    wire  [31:0]     read_data;
    wire             ready;
    wire  [15:0]     sram_dq;
    wire  [c_AW-1:0] sram_addr;
    wire             sram_we_n;
`ifdef SRAM_ADDR_CHECK_EN
    wire             addr_err;
`endif

    always #5 clk = ~clk;

    mem_sram_ctrl #(
        .BASE_ADDR (c_BASE),
        .SRAM_WAIT (c_W),
        .SRAM_AW   (c_AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n)
`ifdef SRAM_ADDR_CHECK_EN
        ,
        .addr_err   (addr_err)
`endif
    );

    // Asynchronous SRAM: output always enabled, write committed mid-cycle while WE_N is low.
    logic [15:0] sram [0:63];
    assign sram_dq = sram_we_n ? sram[sram_addr[5:0]] : 16'hzzzz;
    always @(negedge clk) if (!sram_we_n) sram[sram_addr[5:0]] <= sram_dq;

    logic [31:0]     gm [logic [31:0]];
    logic [31:0]     m_rd;
    logic            e_ready, e_we_n, e_err;
    logic [c_AW-1:0] e_addr;
    logic [15:0]     e_dq;
    logic [31:0]     e_rd;
    bit              chk_en = 1'b0;
    int              n_chk  = 0;
    int              n_fail = 0;
    int              cyc    = 0;
    int              ready_rise = -1;
    logic            prev_ready = 1'b1;
    int              t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ready === 1'b1 && prev_ready !== 1'b1) ready_rise = cyc;
        prev_ready = ready;
        if (chk_en) begin
            check("ready", 32'(ready), 32'(e_ready));
            check("we_n", 32'(sram_we_n), 32'(e_we_n));
            check("sram_addr", 32'(sram_addr), 32'(e_addr));
            check("read_data", read_data, e_rd);
            if (!e_we_n) check("dq", 32'(sram_dq), 32'(e_dq));
`ifdef SRAM_ADDR_CHECK_EN
            check("addr_err", 32'(addr_err), 32'(e_err));
`endif
        end
    end

    task automatic idle(input int n);
        rd_en = 1'b0; wr_en = 1'b0;
        e_ready = 1'b1; e_we_n = 1'b1; e_addr = '0; e_rd = m_rd; e_err = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Timeline of one access starting in IDLE at cycle 0; DONE lands at cycle 2*W+1.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ix, old, nw;
        ix  = ((a - c_BASE) >> 2) & c_MASK;
        old = m_rd;
        nw  = wr ? old : (gm.exists(ix) ? gm[ix] : 32'h0);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int c = 0; c <= 2 * c_W + 1; c++) begin
            e_ready = (c == 2 * c_W + 1);
            e_we_n  = !(wr && c >= 1 && c <= 2 * c_W);
            if (c >= 1 && c <= c_W)            e_addr = {ix[c_AW-2:0], 1'b0};
            else if (c > c_W && c <= 2 * c_W)  e_addr = {ix[c_AW-2:0], 1'b1};
            else                               e_addr = '0;
            e_dq = (c <= c_W) ? d[15:0] : d[31:16];
            if (!wr && c > c_W && c <= 2 * c_W) e_rd = {old[31:16], nw[15:0]};
            else if (!wr && c == 2 * c_W + 1)   e_rd = nw;
            else                                e_rd = old;
            e_err = 1'b0;
            @(posedge clk); #1;
        end
        m_rd = nw;
        if (wr) gm[ix] = d;
    endtask

`ifdef SRAM_ADDR_CHECK_EN
    task automatic access_err(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        for (int c = 0; c <= 1; c++) begin
            e_ready = (c == 1); e_we_n = 1'b1; e_addr = '0; e_rd = m_rd; e_err = (c == 1);
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) sram[i] = 16'h0;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        m_rd = 32'h0;
        e_ready = 1'b1; e_we_n = 1'b1; e_addr = '0; e_rd = '0; e_err = 1'b0; e_dq = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_sram_addr", 32'(sram_addr), 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;
        idle(3);

        t0 = cyc;
        access(1'b0, 1'b1, 32'h400, 32'hDEADBEEF);
        check("store_latency", 32'(ready_rise - t0), 32'd5);
        check("sram_w0", 32'(sram[0]), 32'h0000BEEF);
        check("sram_w1", 32'(sram[1]), 32'h0000DEAD);
        idle(2);
        access(1'b1, 1'b0, 32'h400, 32'h0);
        check("load_0x400", read_data, 32'hDEADBEEF);
        idle(1);

        access(1'b0, 1'b1, 32'h408, 32'h12345678);
        check("sram_w4", 32'(sram[4]), 32'h00005678);
        check("sram_w5", 32'(sram[5]), 32'h00001234);
        access(1'b1, 1'b0, 32'h408, 32'h0);
        check("load_0x408", read_data, 32'h12345678);
        idle(1);

        t0 = cyc;
        access(1'b0, 1'b1, 32'h410, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h410, 32'h0);
        check("b2b_latency", 32'(ready_rise - t0), 32'd11);
        check("load_0x410", read_data, 32'h0BADF00D);
        idle(1);

        access(1'b1, 1'b1, 32'h404, 32'hCAFEF00D);
        check("both_en_rd_kept", read_data, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'h404, 32'h0);
        check("load_0x404", read_data, 32'hCAFEF00D);
        idle(1);

`ifdef SRAM_ADDR_CHECK_EN
        access_err(1'b0, 1'b1, 32'h3FC, 32'h11223344);
        access_err(1'b1, 1'b0, 32'h00080400, 32'h0);
        check("err_no_write", 32'(sram[62]), 32'h0);
        idle(1);
`else
        access(1'b0, 1'b1, 32'h3FC, 32'h11223344);
        check("wrap_lo", 32'(sram[62]), 32'h00003344);
        check("wrap_hi", 32'(sram[63]), 32'h00001122);
        access(1'b1, 1'b0, 32'h3FC, 32'h0);
        check("load_wrap", read_data, 32'h11223344);
        idle(1);
`endif
        idle(5);

        chk_en = 1'b0;
        rd_en = 1'b0; wr_en = 1'b1; address = 32'h40C; write_data = 32'hA5A55A5A;
        repeat (3) begin @(posedge clk); #1; end
        check("hi_phase_we_n", 32'(sram_we_n), 32'd0);
        check("hi_phase_addr", 32'(sram_addr), 32'd7);
        #2 rst = 1'b0;
        #1;
        check("abort_we_n", 32'(sram_we_n), 32'd1);
        check("abort_read_data", read_data, 32'h0);
        check("abort_sram_addr", 32'(sram_addr), 32'd0);
        wr_en = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        m_rd = 32'h0;
        check("abort_lo_written", 32'(sram[6]), 32'h00005A5A);
        check("abort_no_hi_write", 32'(sram[7]), 32'h0);
        chk_en = 1'b1;
        idle(3);
        access(1'b1, 1'b0, 32'h400, 32'h0);
        check("load_after_reset", read_data, 32'hDEADBEEF);
        idle(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
